// File: rtl/spi_master.sv
// spi_master: transmit-only SPI master with a free-running divided sclk and active-low cs framing.
//   clk  : system clock; all logic is on its rising edge
//   rst  : asynchronous, active-high reset
//   newd : one-clk strobe requesting one frame; din is captured on the same edge
//   din  : DATA_W-bit parallel word to transmit
//   sclk : free-running serial clock, period 2*CLK_DIV clk cycles, low in reset
//   cs   : chip select, active low, low for exactly DATA_W sclk periods per frame
//   mosi : serial data, updated on sclk rise events, 0 outside a frame
// Build option: define SPI_MSB_FIRST_EN to shift MSB first; default is LSB first.
module spi_master #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    output logic              sclk,
    output logic              cs,
    output logic              mosi
);
    localparam int CW = $clog2(DATA_W + 1);
    typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, DONE = 2'b10} state_t;
    state_t            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic              sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d, pending_q, pending_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_adv;
    logic [CW-1:0]     bit_q, bit_d;
    logic              wrap, rise, out_bit;
    assign wrap = div_q == 8'(CLK_DIV - 1);
    // The FSM only moves on the sclk 0->1 toggle, so mosi changes a half period before the slave's falling-edge sample.
    assign rise = wrap && !sclk_q;
    // The outgoing bit is always at one end of the shift register, which then advances toward it.
`ifdef SPI_MSB_FIRST_EN
    assign out_bit   = shift_q[DATA_W-1];
    assign shift_adv = shift_q << 1;
`else
    assign out_bit   = shift_q[0];
    assign shift_adv = shift_q >> 1;
`endif
    always_comb begin
        div_d     = wrap ? 8'd0 : div_q + 8'd1;
        sclk_d    = wrap ? ~sclk_q : sclk_q;
        state_d   = state_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        pending_d = pending_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        if (state_q == IDLE && !pending_q && newd) begin
            shift_d   = din;
            pending_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                if (rise && pending_q) begin
                    cs_d      = 1'b0;
                    mosi_d    = out_bit;
                    shift_d   = shift_adv;
                    bit_d     = CW'(1);
                    pending_d = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (rise) begin
                    if (bit_q < CW'(DATA_W)) begin
                        mosi_d  = out_bit;
                        shift_d = shift_adv;
                        bit_d   = bit_q + 1'b1;
                    end else begin
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (rise) begin
                    bit_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            pending_q <= 1'b0;
            shift_q   <= '0;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            pending_q <= pending_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
        end
    end
    assign sclk = sclk_q;
    assign cs   = cs_q;
    assign mosi = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master.
module tb_spi_master;
    localparam int DW = 12;
    localparam int CD = 10;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          newd = 1'b0;
    logic [DW-1:0] din = '0;
    logic          sclk, cs, mosi;
    int            checks = 0;
    int            errors = 0;
    always #5 clk = ~clk;
    spi_master #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .newd(newd), .din(din), .sclk(sclk), .cs(cs), .mosi(mosi)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wait_edge(input logic to, input string tag);
        logic p;
        logic seen;
        p = sclk;
        seen = 1'b0;
        for (int n = 0; n < 4 * CD && !seen; n++) begin
            @(negedge clk);
            if (p === ~to && sclk === to) seen = 1'b1;
            p = sclk;
        end
        if (!seen) check({tag, "_sclk_timeout"}, 0, 1);
    endtask
    task automatic send(input logic [DW-1:0] d);
        @(negedge clk);
        din  = d;
        newd = 1'b1;
        @(negedge clk);
        newd = 1'b0;
    endtask
    task automatic wait_cs_low(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 6 * CD && !seen; n++) begin
            @(negedge clk);
            if (cs === 1'b0) seen = 1'b1;
        end
        if (!seen) check({tag, "_cs_timeout"}, 0, 1);
    endtask
    task automatic rx_frame(input logic [DW-1:0] d, input logic [DW-1:0] word, input string tag, input bit inject);
        logic [DW-1:0] w;
        logic          e;
        w = '0;
        wait_cs_low(tag);
        check({tag, "_cs_fall_on_rise"}, 32'(sclk), 1);
        for (int i = 0; i < DW; i++) begin
            wait_edge(1'b0, tag);
            check($sformatf("%s_cs_low%0d", tag, i), 32'(cs), 0);
`ifdef SPI_MSB_FIRST_EN
            e = d[DW-1-i];
            w[DW-1-i] = mosi;
`else
            e = d[i];
            w[i] = mosi;
`endif
            check($sformatf("%s_bit%0d", tag, i), 32'(mosi), 32'(e));
            if (inject && i == 4) send(12'h456);
        end
        check({tag, "_word"}, 32'(w), 32'(word));
        wait_edge(1'b1, tag);
        check({tag, "_cs_end"}, 32'(cs), 1);
        check({tag, "_mosi_end"}, 32'(mosi), 0);
        wait_edge(1'b1, tag);
        check({tag, "_idle"}, 32'(dut.state_q), 0);
    endtask
    initial begin
        int n;
        logic p;
        logic lows;
        repeat (2) @(negedge clk);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_cs", 32'(cs), 1);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_state", 32'(dut.state_q), 0);
        rst = 1'b0;
        wait_edge(1'b1, "per");
        n = 0;
        p = sclk;
        for (int k = 0; k < 4 * CD; k++) begin
            @(negedge clk);
            n++;
            if (p === 1'b1 && sclk === 1'b0) break;
            p = sclk;
        end
        check("sclk_high_len", n, 10);
        n = 0;
        p = sclk;
        for (int k = 0; k < 4 * CD; k++) begin
            @(negedge clk);
            n++;
            if (p === 1'b0 && sclk === 1'b1) break;
            p = sclk;
        end
        check("sclk_low_len", n, 10);
        check("idle_cs", 32'(cs), 1);
        send(12'hA5C);
        rx_frame(12'hA5C, 12'hA5C, "a5c", 1'b0);
        send(12'h000);
        rx_frame(12'h000, 12'h000, "zero", 1'b0);
        send(12'hFFF);
        rx_frame(12'hFFF, 12'hFFF, "ones", 1'b0);
        send(12'h123);
        rx_frame(12'h123, 12'h123, "busy", 1'b1);
        lows = 1'b0;
        for (int k = 0; k < 6 * CD; k++) begin
            @(negedge clk);
            if (cs !== 1'b1) lows = 1'b1;
        end
        check("busy_no_second", 32'(lows), 0);
        send(12'h9A7);
        wait_cs_low("abort");
        for (int i = 0; i < 5; i++) wait_edge(1'b0, "abort");
        #1 rst = 1'b1;
        #1;
        check("abort_cs", 32'(cs), 1);
        check("abort_mosi", 32'(mosi), 0);
        check("abort_sclk", 32'(sclk), 0);
        check("abort_state", 32'(dut.state_q), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(12'h3C5);
        rx_frame(12'h3C5, 12'h3C5, "post_rst", 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
